mul8_err_monitor: RTL and testbench

// Downstream consumer of an 8x8 approximate multiplier. Takes each operand pair and the

---
 rtl/mul8_err_monitor_if.sv | 13 +
 rtl/mul8_err_monitor.sv | 169 ++++++++++++++++
 tb/tb_mul8_err_monitor.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul8_err_monitor_if.sv
// Sample bus between an 8x8 multiplier under test and its error monitor.
// The producer drives operands, approximate product and valid; the monitor
// answers with ready.
interface mul8_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;

  modport master (output in_valid, A, B, P, input in_ready);
  modport slave  (input in_valid, A, B, P, output in_ready);
endinterface

// File: rtl/mul8_err_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier.
// A 3-stage pipe captures each sample (S1), computes the exact product and
// the absolute error (S2), then folds it into saturating run statistics (S3).
module mul8_err_monitor #(
  parameter int unsigned N_SAMPLES = 65536,
  parameter int unsigned ACC_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  mul8_err_monitor_if.slave     smp,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_W-1:0]      sum_abs_err,
  output logic [15:0]           wce,
  output logic [7:0]            wce_a,
  output logic [7:0]            wce_b,
  output logic [ACC_W-1:0]      err_cnt,
  output logic [ACC_W-1:0]      sample_cnt
);

  localparam logic [ACC_W-1:0] N_CNT  = ACC_W'(N_SAMPLES);
  localparam logic [ACC_W-1:0] N_LAST = ACC_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  // vld_q[0]: S1 holds a sample, vld_q[1]: S2 holds a sample
  logic [1:0]       vld_q, vld_d;
  logic [7:0]       a1_q, a1_d, b1_q, b1_d;
  logic [15:0]      p1_q, p1_d;
  logic [7:0]       a2_q, a2_d, b2_q, b2_d;
  logic [15:0]      err2_q, err2_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [15:0]      wce_q, wce_d;
  logic [7:0]       wce_a_q, wce_a_d, wce_b_q, wce_b_d;
  logic [ACC_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] sample_cnt_q, sample_cnt_d;

  logic             xfer;
  logic [15:0]      exact;
  logic [ACC_W:0]   sum_ext;

  // start takes priority over a sample offered in the same cycle
  assign smp.in_ready = (state_q == S_RUN) && (sample_cnt_q < N_CNT) && !start;
  assign xfer         = smp.in_valid && smp.in_ready;

  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign sum_abs_err = sum_q;
  assign wce         = wce_q;
  assign wce_a       = wce_a_q;
  assign wce_b       = wce_b_q;
  assign err_cnt     = err_cnt_q;
  assign sample_cnt  = sample_cnt_q;

  // Run control: leave DRAIN once S1 is empty, the last sample is then in S2
  // and lands in the statistics on the same edge that raises done.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (xfer && (sample_cnt_q == N_LAST)) state_d = S_DRAIN;
        S_DRAIN: if (!vld_q[0]) state_d = S_DONE;
        default: ;
      endcase
    end
  end

  // Pipeline and accumulators; start flushes the pipe and clears the stats
  always_comb begin
    vld_d        = {vld_q[0], xfer};
    a1_d         = a1_q;
    b1_d         = b1_q;
    p1_d         = p1_q;
    a2_d         = a2_q;
    b2_d         = b2_q;
    err2_d       = err2_q;
    sum_d        = sum_q;
    wce_d        = wce_q;
    wce_a_d      = wce_a_q;
    wce_b_d      = wce_b_q;
    err_cnt_d    = err_cnt_q;
    sample_cnt_d = sample_cnt_q;

    exact   = {8'd0, a1_q} * {8'd0, b1_q};
    sum_ext = {1'b0, sum_q} + {{(ACC_W-15){1'b0}}, err2_q};

    // S1: capture the offered sample; the count moves now so in_ready
    // drops right after the final transfer
    if (xfer) begin
      a1_d         = smp.A;
      b1_d         = smp.B;
      p1_d         = smp.P;
      sample_cnt_d = sample_cnt_q + 1'b1;
    end

    // S2: absolute error via ordered subtraction, never wraps
    if (vld_q[0]) begin
      a2_d   = a1_q;
      b2_d   = b1_q;
      err2_d = (exact >= p1_q) ? (exact - p1_q) : (p1_q - exact);
    end

    // S3: saturating sums; strict compare keeps the earliest worst case
    if (vld_q[1]) begin
      sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if ((err2_q != 16'd0) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
      if (err2_q > wce_q) begin
        wce_d   = err2_q;
        wce_a_d = a2_q;
        wce_b_d = b2_q;
      end
    end

    if (start) begin
      vld_d        = '0;
      sum_d        = '0;
      wce_d        = '0;
      wce_a_d      = '0;
      wce_b_d      = '0;
      err_cnt_d    = '0;
      sample_cnt_d = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      a1_q         <= '0;
      b1_q         <= '0;
      p1_q         <= '0;
      a2_q         <= '0;
      b2_q         <= '0;
      err2_q       <= '0;
      sum_q        <= '0;
      wce_q        <= '0;
      wce_a_q      <= '0;
      wce_b_q      <= '0;
      err_cnt_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      vld_q        <= vld_d;
      a1_q         <= a1_d;
      b1_q         <= b1_d;
      p1_q         <= p1_d;
      a2_q         <= a2_d;
      b2_q         <= b2_d;
      err2_q       <= err2_d;
      sum_q        <= sum_d;
      wce_q        <= wce_d;
      wce_a_q      <= wce_a_d;
      wce_b_q      <= wce_b_d;
      err_cnt_q    <= err_cnt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

endmodule

// File: tb/tb_mul8_err_monitor.sv
// Directed bench for mul8_err_monitor: a table of 4-sample runs on a N=4
// instance, hand sequences for restart/reset, a 16-bit saturation instance
// and a randomly throttled sweep against a reference stats model.
module tb_mul8_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b, start_c;

  mul8_err_monitor_if ifa ();
  mul8_err_monitor_if ifb ();
  mul8_err_monitor_if ifc ();

  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [31:0] sum_a, ecnt_a, scnt_a, sum_c, ecnt_c, scnt_c;
  logic [15:0] sum_b, ecnt_b, scnt_b;
  logic [15:0] wce_a_o, wce_b_o, wce_c_o;
  logic [7:0]  wa_a, wb_a, wa_b, wb_b, wa_c, wb_c;

  mul8_err_monitor #(.N_SAMPLES(4), .ACC_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .smp(ifa),
    .busy(busy_a), .done(done_a), .sum_abs_err(sum_a), .wce(wce_a_o),
    .wce_a(wa_a), .wce_b(wb_a), .err_cnt(ecnt_a), .sample_cnt(scnt_a));

  mul8_err_monitor #(.N_SAMPLES(2), .ACC_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .smp(ifb),
    .busy(busy_b), .done(done_b), .sum_abs_err(sum_b), .wce(wce_b_o),
    .wce_a(wa_b), .wce_b(wb_b), .err_cnt(ecnt_b), .sample_cnt(scnt_b));

  mul8_err_monitor #(.N_SAMPLES(512), .ACC_W(32)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .smp(ifc),
    .busy(busy_c), .done(done_c), .sum_abs_err(sum_c), .wce(wce_c_o),
    .wce_a(wa_c), .wce_b(wb_c), .err_cnt(ecnt_c), .sample_cnt(scnt_c));

  typedef struct packed {
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [3:0][15:0] p;
    logic [31:0]      sum;
    logic [15:0]      wce;
    logic [7:0]       wa;
    logic [7:0]       wb;
    logic [31:0]      ecnt;
  } run_t;

  run_t runs [5];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start_a(input logic with_valid);
    start_a = 1'b1;
    ifa.in_valid = with_valid;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    ifa.in_valid = 1'b0;
    #1;
  endtask

  task automatic send_a(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    ifa.A = a;
    ifa.B = b;
    ifa.P = p;
    ifa.in_valid = 1'b1;
    #1;
    chk("a_in_ready", {31'd0, ifa.in_ready}, 32'd1);
    tick();
    ifa.in_valid = 1'b0;
  endtask

  task automatic wait_done_a(output int lat);
    lat = 0;
    while (!done_a && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic stats_a(input string nm, input logic [31:0] s, input logic [15:0] w,
                         input logic [7:0] wa, input logic [7:0] wb, input logic [31:0] e,
                         input logic [31:0] n);
    chk({nm, "_sum"},  sum_a, s);
    chk({nm, "_wce"},  {16'd0, wce_a_o}, {16'd0, w});
    chk({nm, "_wa"},   {24'd0, wa_a}, {24'd0, wa});
    chk({nm, "_wb"},   {24'd0, wb_a}, {24'd0, wb});
    chk({nm, "_ecnt"}, ecnt_a, e);
    chk({nm, "_scnt"}, scnt_a, n);
  endtask

  function automatic logic [15:0] approx_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ex;
    ex = {8'd0, a} * {8'd0, b};
    return a[7] ? ex + {14'd0, b[1:0]} : ex & 16'hFFF8;
  endfunction

  initial begin
    int lat;
    int idx;
    int cyc;
    logic        v, rdy;
    logic [7:0]  ca, cb;
    logic [15:0] cp, cex, cerr;
    logic [31:0] m_sum, m_ecnt;
    logic [15:0] m_wce;
    logic [7:0]  m_wa, m_wb;

    // a/b/p listed sample 3 down to sample 0 (index 0 sent first)
    runs[0] = '{a: {8'd16, 8'd0, 8'd255, 8'd3}, b: {8'd16, 8'd7, 8'd255, 8'd5},
                p: {16'd256, 16'd0, 16'd65025, 16'd15},
                sum: 32'd0, wce: 16'd0, wa: 8'd0, wb: 8'd0, ecnt: 32'd0};
    runs[1] = '{a: {8'd0, 8'd1, 8'd2, 8'd255}, b: {8'd0, 8'd1, 8'd3, 8'd255},
                p: {16'd0, 16'd1, 16'd7, 16'd0},
                sum: 32'd65026, wce: 16'd65025, wa: 8'd255, wb: 8'd255, ecnt: 32'd2};
    runs[2] = '{a: {8'd0, 8'd0, 8'd5, 8'd10}, b: {8'd0, 8'd0, 8'd4, 8'd10},
                p: {16'd0, 16'd0, 16'd30, 16'd90},
                sum: 32'd20, wce: 16'd10, wa: 8'd10, wb: 8'd10, ecnt: 32'd2};
    runs[3] = '{a: {8'd7, 8'd200, 8'd1, 8'd1}, b: {8'd9, 8'd100, 8'd2, 8'd1},
                p: {16'd60, 16'd20000, 16'd65535, 16'd0},
                sum: 32'd65537, wce: 16'd65533, wa: 8'd1, wb: 8'd2, ecnt: 32'd3};
    runs[4] = '{a: {8'd2, 8'd12, 8'd3, 8'd4}, b: {8'd2, 8'd12, 8'd3, 8'd4},
                p: {16'd3, 16'd135, 16'd0, 16'd10},
                sum: 32'd25, wce: 16'd9, wa: 8'd3, wb: 8'd3, ecnt: 32'd4};

    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ifa.in_valid = 1'b0; ifa.A = '0; ifa.B = '0; ifa.P = '0;
    ifb.in_valid = 1'b0; ifb.A = '0; ifb.B = '0; ifb.P = '0;
    ifc.in_valid = 1'b0; ifc.A = '0; ifc.B = '0; ifc.P = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_ready", {31'd0, ifa.in_ready}, 32'd0);
    stats_a("rst", 32'd0, 16'd0, 8'd0, 8'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table of complete 4-sample runs
    for (int r = 0; r < 5; r++) begin
      pulse_start_a(1'b0);
      chk("run_busy", {31'd0, busy_a}, 32'd1);
      chk("run_zero_sum", sum_a, 32'd0);
      for (int k = 0; k < 4; k++) send_a(runs[r].a[k], runs[r].b[k], runs[r].p[k]);
      chk("run_ready_low", {31'd0, ifa.in_ready}, 32'd0);
      wait_done_a(lat);
      chk("run_done_latency", lat, 32'd2);
      chk("run_busy_low", {31'd0, busy_a}, 32'd0);
      stats_a($sformatf("run%0d", r), runs[r].sum, runs[r].wce, runs[r].wa, runs[r].wb,
              runs[r].ecnt, 32'd4);
    end

    // Offers after the run are ignored and stats hold while done
    ifa.A = 8'd255; ifa.B = 8'd255; ifa.P = 16'd0; ifa.in_valid = 1'b1;
    tick(); tick(); tick();
    ifa.in_valid = 1'b0;
    chk("hold_done", {31'd0, done_a}, 32'd1);
    stats_a("hold", 32'd25, 16'd9, 8'd3, 8'd3, 32'd4, 32'd4);

    // Restart mid-run with a sample offered alongside start; pipe must flush
    pulse_start_a(1'b0);
    send_a(8'd255, 8'd255, 16'd0);
    send_a(8'd255, 8'd255, 16'd0);
    ifa.A = 8'd200; ifa.B = 8'd200; ifa.P = 16'd0;
    pulse_start_a(1'b1);
    stats_a("restart", 32'd0, 16'd0, 8'd0, 8'd0, 32'd0, 32'd0);
    chk("restart_busy", {31'd0, busy_a}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("restart_no_stale", sum_a, 32'd0);
    chk("restart_no_stale_cnt", scnt_a, 32'd0);
    for (int k = 0; k < 4; k++) send_a(runs[0].a[k], runs[0].b[k], runs[0].p[k]);
    wait_done_a(lat);
    chk("restart_latency", lat, 32'd2);
    stats_a("restart_run", 32'd0, 16'd0, 8'd0, 8'd0, 32'd0, 32'd4);

    // Asynchronous reset in the middle of a run
    pulse_start_a(1'b0);
    send_a(8'd255, 8'd255, 16'd0);
    send_a(8'd255, 8'd255, 16'd0);
    tick();
    rst_n = 1'b0;
    #1;
    stats_a("midrst", 32'd0, 16'd0, 8'd0, 8'd0, 32'd0, 32'd0);
    chk("midrst_busy", {31'd0, busy_a}, 32'd0);
    chk("midrst_ready", {31'd0, ifa.in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start_a(1'b0);
    for (int k = 0; k < 4; k++) send_a(runs[2].a[k], runs[2].b[k], runs[2].p[k]);
    wait_done_a(lat);
    chk("midrst_latency", lat, 32'd2);
    stats_a("midrst_run", 32'd20, 16'd10, 8'd10, 8'd10, 32'd2, 32'd4);

    // 16-bit accumulator saturation
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    ifb.A = 8'd255; ifb.B = 8'd255; ifb.P = 16'd0; ifb.in_valid = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("sat_ready", {31'd0, ifb.in_ready}, 32'd1);
      tick();
    end
    ifb.in_valid = 1'b0;
    lat = 0;
    while (!done_b && lat < 20) begin
      tick();
      lat++;
    end
    chk("sat_latency", lat, 32'd2);
    chk("sat_sum", {16'd0, sum_b}, 32'd65535);
    chk("sat_wce", {16'd0, wce_b_o}, 32'd65025);
    chk("sat_ecnt", {16'd0, ecnt_b}, 32'd2);
    chk("sat_scnt", {16'd0, scnt_b}, 32'd2);

    // Throttled sweep against a reference statistics model
    m_sum = '0; m_ecnt = '0; m_wce = '0; m_wa = '0; m_wb = '0;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    #1;
    idx = 0;
    cyc = 0;
    while (idx < 512 && cyc < 4000) begin
      ca = 8'(idx * 37 + idx / 256);
      cb = 8'(idx * 101 + 3);
      cp = approx_mul(ca, cb);
      v  = 1'($urandom_range(0, 1));
      ifc.A = ca; ifc.B = cb; ifc.P = cp; ifc.in_valid = v;
      #1;
      rdy = ifc.in_ready;
      tick();
      if (v && rdy) begin
        cex  = {8'd0, ca} * {8'd0, cb};
        cerr = (cex > cp) ? cex - cp : cp - cex;
        m_sum = m_sum + {16'd0, cerr};
        if (cerr != 16'd0) m_ecnt = m_ecnt + 1;
        if (cerr > m_wce) begin
          m_wce = cerr;
          m_wa  = ca;
          m_wb  = cb;
        end
        idx++;
      end
      cyc++;
    end
    chk("sweep_accepted", idx, 32'd512);
    ifc.in_valid = 1'b1;
    #1;
    chk("sweep_ready_low", {31'd0, ifc.in_ready}, 32'd0);
    tick();
    ifc.in_valid = 1'b0;
    lat = 0;
    while (!done_c && lat < 20) begin
      tick();
      lat++;
    end
    chk("sweep_done", {31'd0, done_c}, 32'd1);
    chk("sweep_sum", sum_c, m_sum);
    chk("sweep_wce", {16'd0, wce_c_o}, {16'd0, m_wce});
    chk("sweep_wa", {24'd0, wa_c}, {24'd0, m_wa});
    chk("sweep_wb", {24'd0, wb_c}, {24'd0, m_wb});
    chk("sweep_ecnt", ecnt_c, m_ecnt);
    chk("sweep_scnt", scnt_c, 32'd512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
